// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, single-outstanding icache handshake,
// and a QDEPTH-entry {pc, instruction} FIFO feeding decode, with redirect flush.
module fetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 'h400000,
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            icache_rqst,
    output logic [XLEN-1:0] icache_addr,
    input  logic            icache_done,
    input  logic [XLEN-1:0] icache_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst
);

    localparam int unsigned NSLICE = XLEN / ILEN;
    localparam int unsigned IB     = $clog2(ILEN / 8);
    localparam int unsigned PW     = $clog2(QDEPTH);
    localparam int unsigned CW     = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] pc_mem   [QDEPTH];
    logic [ILEN-1:0] inst_mem [QDEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   cnt_next;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] slice_no;
    logic [ILEN-1:0] sel_inst;

    assign icache_rqst = (state != S_IDLE);
    assign icache_addr = addr_q;
    assign out_valid   = (count != '0);
    assign out_pc      = pc_mem[rd_ptr];
    assign out_inst    = inst_mem[rd_ptr];
    assign pc_inc      = fetch_pc + XLEN'(4);

    always_comb begin
        push     = (state == S_WAIT) && icache_done && !redirect_valid;
        pop      = out_valid && out_ready && !redirect_valid;
        cnt_next = count + CW'(push) - CW'(pop);
        // Pick the ILEN-wide slice of the aligned word addressed by the request.
        slice_no = (addr_q >> IB) & XLEN'(NSLICE - 1);
        sel_inst = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (slice_no == XLEN'(i)) sel_inst = icache_data[i*ILEN +: ILEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            addr_q   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            if (redirect_valid) begin
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else begin
                count <= cnt_next;
                if (push) begin
                    pc_mem[wr_ptr]   <= addr_q;
                    inst_mem[wr_ptr] <= sel_inst;
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (!redirect_valid && count < CW'(QDEPTH)) begin
                        state  <= S_WAIT;
                        addr_q <= fetch_pc;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        state <= icache_done ? S_IDLE : S_DISCARD;
                    end else if (icache_done) begin
                        fetch_pc <= pc_inc;
                        // Back-to-back request unless this push filled the FIFO.
                        if (cnt_next < CW'(QDEPTH)) addr_q <= pc_inc;
                        else                        state  <= S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (icache_done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, lane select, backpressure,
// redirects (delayed and same-cycle), PC wrap and asynchronous reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        icache_rqst;
    logic [63:0] icache_addr;
    logic        icache_done = 1'b0;
    logic [63:0] icache_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .XLEN(64), .ILEN(32), .RESET_PC(64'h400000), .QDEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .icache_rqst(icache_rqst), .icache_addr(icache_addr),
        .icache_done(icache_done), .icache_data(icache_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_rqst", 64'(icache_rqst), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc", out_pc, 64'h0);
        chk("rst_inst", 64'(out_inst), 64'h0);

        // Streaming: done every cycle, decode always ready.
        tick(); rst = 1'b0;
        tick();
        chk("s_rqst0", 64'(icache_rqst), 64'd1);
        chk("s_addr0", icache_addr, 64'h400000);
        icache_done = 1'b1; icache_data = 64'hAAAAAAAA_BBBBBBBB; out_ready = 1'b1;
        tick();
        chk("s_addr1", icache_addr, 64'h400004);
        chk("s_valid1", 64'(out_valid), 64'd1);
        chk("s_pc1", out_pc, 64'h400000);
        chk("s_inst1", 64'(out_inst), 64'hBBBBBBBB);
        tick();
        chk("s_addr2", icache_addr, 64'h400008);
        chk("s_pc2", out_pc, 64'h400004);
        chk("s_inst2", 64'(out_inst), 64'hAAAAAAAA);
        tick();
        chk("s_addr3", icache_addr, 64'h40000C);
        chk("s_pc3", out_pc, 64'h400008);

        // Backpressure: restart from reset, fill the FIFO with decode stalled.
        icache_done = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("r2_valid", 64'(out_valid), 64'd0);
        tick(); rst = 1'b0; icache_done = 1'b1;
        tick();
        chk("f_addr0", icache_addr, 64'h400000);
        tick(); tick(); tick();
        chk("f_addr3", icache_addr, 64'h40000C);
        chk("f_rqst3", 64'(icache_rqst), 64'd1);
        tick();
        chk("f_full_rqst", 64'(icache_rqst), 64'd0);
        chk("f_full_pc", out_pc, 64'h400000);
        tick();
        chk("f_stall_rqst", 64'(icache_rqst), 64'd0);
        icache_done = 1'b0; out_ready = 1'b1;
        tick();
        chk("d_pc1", out_pc, 64'h400004);
        chk("d_rqst1", 64'(icache_rqst), 64'd0);
        tick();
        chk("d_pc2", out_pc, 64'h400008);
        chk("d_rqst2", 64'(icache_rqst), 64'd1);
        chk("d_resume", icache_addr, 64'h400010);
        tick();
        chk("d_pc3", out_pc, 64'h40000C);
        tick();
        chk("d_empty", 64'(out_valid), 64'd0);

        // Redirect while waiting; late response must be dropped.
        redirect_valid = 1'b1; redirect_pc = 64'h80000002;
        tick();
        redirect_valid = 1'b0;
        chk("rd_valid", 64'(out_valid), 64'd0);
        chk("rd_hold", icache_addr, 64'h400010);
        tick(); tick();
        chk("rd_rqst", 64'(icache_rqst), 64'd1);
        icache_done = 1'b1; icache_data = 64'hDEADBEEF_DEADBEEF;
        tick();
        icache_done = 1'b0;
        chk("rd_drop", 64'(out_valid), 64'd0);
        chk("rd_idle", 64'(icache_rqst), 64'd0);
        tick();
        chk("rd_addr", icache_addr, 64'h80000000);

        // Redirect coinciding with done and a pop.
        icache_done = 1'b1; icache_data = 64'h11111111_22222222;
        tick();
        chk("sc_valid0", 64'(out_valid), 64'd1);
        chk("sc_pc0", out_pc, 64'h80000000);
        redirect_valid = 1'b1; redirect_pc = 64'h1000;
        tick();
        redirect_valid = 1'b0; icache_done = 1'b0;
        chk("sc_flush", 64'(out_valid), 64'd0);
        chk("sc_idle", 64'(icache_rqst), 64'd0);
        tick();
        chk("sc_addr", icache_addr, 64'h1000);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 64'hFFFFFFFF_FFFFFFFC;
        tick();
        redirect_valid = 1'b0; icache_done = 1'b1;
        tick();
        icache_done = 1'b0;
        tick();
        chk("w_addr", icache_addr, 64'hFFFFFFFF_FFFFFFFC);
        icache_done = 1'b1; icache_data = 64'h12345678_9ABCDEF0;
        tick();
        icache_done = 1'b0;
        chk("w_next", icache_addr, 64'h0);
        chk("w_pc", out_pc, 64'hFFFFFFFF_FFFFFFFC);
        chk("w_inst", 64'(out_inst), 64'h12345678);

        // Asynchronous reset mid-WAIT, then a stray done.
        #2 rst = 1'b1;
        #1;
        chk("ar_rqst", 64'(icache_rqst), 64'd0);
        chk("ar_valid", 64'(out_valid), 64'd0);
        icache_done = 1'b1;
        tick(); rst = 1'b0;
        tick();
        chk("ar_addr", icache_addr, 64'h400000);
        chk("ar_nopush", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
